// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
//   Shared types and helpers for the parametrised round-robin arbiter.
//
//   Contents:
//     state_t     - arbiter FSM state (IDLE, GRANT)
//     ARB_MAX_N   - largest supported requester count
//     ARB_IDW_MAX - index width needed for ARB_MAX_N requesters
//     onehot2bin  - one-hot to binary index conversion (ARB_MAX_N wide)
// -----------------------------------------------------------------------------
package arbiter_pkg;

    localparam int ARB_MAX_N   = 32;
    localparam int ARB_IDW_MAX = $clog2(ARB_MAX_N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Binary index of the set bit of a one-hot vector. Returns 0 for an
    // all-zero vector; callers qualify the result with their own valid flag.
    function automatic logic [ARB_IDW_MAX-1:0] onehot2bin(
        input logic [ARB_MAX_N-1:0] onehot
    );
        logic [ARB_IDW_MAX-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (onehot[i]) begin
                idx = idx | ARB_IDW_MAX'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational circular priority encoder. Returns the first set bit of
//   req when searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//
//   Parameters:
//     N    - number of request lines (1..32)
//     IDW  - width of ptr / id
//
//   Ports:
//     req     in   N    request vector
//     ptr     in   IDW  index holding highest priority (must be < N)
//     onehot  out  N    one-hot winner, zero when req is zero
//     id      out  IDW  binary index of the winner (0 when none)
//     any     out  1    at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] id,
    output logic           any
);

    // Rotate req right by ptr so the search always starts at bit 0, isolate
    // the lowest set bit, then rotate the result back by the same amount.
    // The doubled vectors turn each rotation into a plain shift.
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   first_rot;
    logic [2*N-1:0] back_dbl;

    always_comb begin
        req_dbl   = {req, req} >> ptr;
        req_rot   = req_dbl[N-1:0];
        first_rot = req_rot & (~req_rot + N'(1));
        back_dbl  = {first_rot, first_rot} << ptr;
        onehot    = back_dbl[2*N-1:N];
        any       = |req;
        id        = IDW'(onehot2bin(ARB_MAX_N'(onehot)));
    end

endmodule

// File: rtl/arbiter_rr_param.sv
// -----------------------------------------------------------------------------
// arbiter_rr_param
//   Parametrised round-robin arbiter with registered one-hot grant, binary
//   grant index and a hold limit that forces rotation when others wait.
//
//   Parameters:
//     N         - number of requesters (1..32)
//     MAX_HOLD  - consecutive grant cycles before forced rotation, 0=unlimited
//     IDW       - derived width of gnt_id ($clog2(N), minimum 1)
//
//   Ports:
//     clk      in   1    clock, all state on rising edge
//     rst_n    in   1    asynchronous active-low reset
//     req      in   N    level-sensitive request vector
//     lock     in   1    suppress preemption (only with ARB_LOCK_EN)
//     gnt      out  N    registered one-hot grant, zero when idle
//     gnt_id   out  IDW  index of current owner, valid with gnt_vld
//     gnt_vld  out  1    any grant bit set
//     preempt  out  1    one-cycle pulse aligned with a hold-limit handoff
//
//   Build option:
//     ARB_LOCK_EN - adds the lock input; while lock=1 and a grant is held,
//                   hold-limit preemption is suppressed (release still works,
//                   hold_cnt keeps counting).
// -----------------------------------------------------------------------------
module arbiter_rr_param
    import arbiter_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
`ifdef ARB_LOCK_EN
    input  logic           lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           preempt
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    // Registered state
    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;

    // Next-state values
    state_t         state_d;
    logic [IDW-1:0] ptr_d;
    logic [HCW-1:0] hold_cnt_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] gnt_id_d;
    logic           preempt_d;

    // Arbitration helpers
    logic [IDW-1:0] owner_next;
    logic [IDW-1:0] pick_base;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_id;
    logic           pick_any;
    logic           owner_req;
    logic           competitors;
    logic           at_limit;
    logic           lock_active;
    logic           do_preempt;

`ifdef ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // Index after the current owner, wrapping N-1 -> 0.
    assign owner_next = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);

    // While granted, a handoff always searches from the owner's successor,
    // so the outgoing owner is last in line. When idle, search from ptr.
    assign pick_base = (state == GRANT) ? owner_next : ptr;

    assign owner_req   = |(req & gnt);
    assign competitors = |(req & ~gnt);
    assign at_limit    = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));
    assign do_preempt  = owner_req && at_limit && competitors && !lock_active;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (pick_base),
        .onehot (pick_onehot),
        .id     (pick_id),
        .any    (pick_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned; that is what keeps this block latch-free.
        state_d    = state;
        ptr_d      = ptr;
        hold_cnt_d = hold_cnt;
        gnt_d      = gnt;
        gnt_id_d   = gnt_id;
        preempt_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_d      = pick_onehot;
                    gnt_id_d   = pick_id;
                    hold_cnt_d = HCW'(1);
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                if (!owner_req || do_preempt) begin
                    // Handoff: release or hold-limit revocation.
                    ptr_d = owner_next;
                    if (pick_any) begin
                        gnt_d      = pick_onehot;
                        gnt_id_d   = pick_id;
                        hold_cnt_d = HCW'(1);
                        preempt_d  = do_preempt;
                    end else begin
                        gnt_d      = '0;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && !at_limit) begin
                    // Keep the grant; count up to the limit and stay there.
                    hold_cnt_d = hold_cnt + HCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            preempt  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge
            // values computed above, independent of statement order.
            state    <= state_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_cnt_d;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
            preempt  <= preempt_d;
        end
    end

    assign gnt_vld = |gnt;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr_param
//   Self-checking bench for arbiter_rr_param. Four instances:
//     a: N=4, MAX_HOLD=8  - reset, hold limit, solo saturation, async reset
//     b: N=4, MAX_HOLD=0  - fair rotation vector table
//     c: N=5, MAX_HOLD=4  - lock sequence (ARB_LOCK_EN) and random vs model
//     d: N=1, MAX_HOLD=2  - random vs model
// -----------------------------------------------------------------------------
module tb_arbiter_rr_param;

    typedef struct {
        int owner;   // -1 when idle
        int ptr;
        int cnt;
        bit pre;
    } model_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic       exp_vld;
        logic [1:0] exp_id;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [4:0] req_c;
    logic [0:0] req_d;
    logic       lock_c;

    logic [3:0] gnt_a, gnt_b;
    logic [4:0] gnt_c;
    logic [0:0] gnt_d;
    logic [1:0] id_a, id_b;
    logic [2:0] id_c;
    logic [0:0] id_d;
    logic       vld_a, vld_b, vld_c, vld_d;
    logic       pre_a, pre_b, pre_c, pre_d;

    int n_checks = 0;
    int n_fail   = 0;

    arbiter_rr_param #(.N(4), .MAX_HOLD(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .preempt(pre_a)
    );

    arbiter_rr_param #(.N(4), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .preempt(pre_b)
    );

    arbiter_rr_param #(.N(5), .MAX_HOLD(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c),
`ifdef ARB_LOCK_EN
        .lock(lock_c),
`endif
        .gnt(gnt_c), .gnt_id(id_c), .gnt_vld(vld_c), .preempt(pre_c)
    );

    arbiter_rr_param #(.N(1), .MAX_HOLD(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .req(req_d),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .gnt(gnt_d), .gnt_id(id_d), .gnt_vld(vld_d), .preempt(pre_d)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eg,
                         input logic ep);
        check({tag, "_gnt"}, 32'(gnt_a), 32'(eg));
        check({tag, "_vld"}, 32'(vld_a), 32'(eg != 4'b0000));
        check({tag, "_pre"}, 32'(pre_a), 32'(ep));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First requester in circular order from base, or -1.
    function automatic int pick(input int n, input int base,
                                input logic [31:0] r);
        for (int i = 0; i < n; i++) begin
            int j;
            j = (base + i) % n;
            if (((r >> j) & 32'd1) != 0) return j;
        end
        return -1;
    endfunction

    // One clock of the arbiter's rules applied to the request seen at the edge.
    function automatic model_t step(input model_t m, input int n, input int mh,
                                    input logic [31:0] r, input bit lk);
        model_t s;
        bit own;
        bit others;
        s     = m;
        s.pre = 1'b0;
        if (s.owner < 0) begin
            s.owner = pick(n, s.ptr, r);
            if (s.owner >= 0) s.cnt = 1;
        end else begin
            own    = ((r >> s.owner) & 32'd1) != 0;
            others = (r & ~(32'd1 << s.owner)) != 0;
            if (!own || (mh != 0 && s.cnt == mh && others && !lk)) begin
                s.pre   = own;
                s.ptr   = (s.owner + 1) % n;
                s.owner = pick(n, s.ptr, r);
                s.cnt   = (s.owner >= 0) ? 1 : 0;
            end else if (mh != 0 && s.cnt < mh) begin
                s.cnt++;
            end
        end
        return s;
    endfunction

    task automatic cmp_model(input string tag, input model_t m,
                             input logic [31:0] g, input logic [31:0] id,
                             input logic v, input logic p);
        logic [31:0] eg;
        eg = (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
        check({tag, "_gnt"}, g, eg);
        check({tag, "_vld"}, 32'(v), 32'(m.owner >= 0));
        if (m.owner >= 0) check({tag, "_id"}, id, 32'(m.owner));
        check({tag, "_pre"}, 32'(p), 32'(m.pre));
    endtask

    initial begin
        vec_t   tbl [7];
        model_t mc;
        model_t md;
        bit     lk;

        // Fair rotation with unlimited hold: each owner drops for one cycle.
        tbl[0] = '{req: 4'b1111, exp_gnt: 4'b0001, exp_vld: 1'b1, exp_id: 2'd0};
        tbl[1] = '{req: 4'b1110, exp_gnt: 4'b0010, exp_vld: 1'b1, exp_id: 2'd1};
        tbl[2] = '{req: 4'b1101, exp_gnt: 4'b0100, exp_vld: 1'b1, exp_id: 2'd2};
        tbl[3] = '{req: 4'b1011, exp_gnt: 4'b1000, exp_vld: 1'b1, exp_id: 2'd3};
        tbl[4] = '{req: 4'b0111, exp_gnt: 4'b0001, exp_vld: 1'b1, exp_id: 2'd0};
        tbl[5] = '{req: 4'b0000, exp_gnt: 4'b0000, exp_vld: 1'b0, exp_id: 2'd0};
        tbl[6] = '{req: 4'b0100, exp_gnt: 4'b0100, exp_vld: 1'b1, exp_id: 2'd2};

        rst_n  = 1'b0;
        req_a  = 4'b1111;
        req_b  = '0;
        req_c  = '0;
        req_d  = '0;
        lock_c = 1'b0;

        // Reset holds everything idle even with all requests up.
        #12;
        chk_a("rst", 4'b0000, 1'b0);
        check("rst_id", 32'(id_a), 32'd0);
        check("rst_d_gnt", 32'(gnt_d), 32'd0);

        rst_n = 1'b1;
        req_a = 4'b0100;
        tick();
        chk_a("first", 4'b0100, 1'b0);
        check("first_id", 32'(id_a), 32'd2);

        // Hold limit: owner 2 drops, search from 3 finds 0; 8 cycles each.
        req_a = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_a("hold0", 4'b0001, 1'b0);
        end
        tick();
        chk_a("limit0", 4'b0010, 1'b1);
        check("limit0_id", 32'(id_a), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_a("hold1", 4'b0010, 1'b0);
        end
        tick();
        chk_a("limit1", 4'b0001, 1'b1);

        // Solo saturation, then a competitor appears.
        req_a = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_a("solo", 4'b0001, 1'b0);
        end
        req_a = 4'b1001;
        tick();
        chk_a("late", 4'b1000, 1'b1);
        check("late_id", 32'(id_a), 32'd3);
        tick();
        chk_a("late_hold", 4'b1000, 1'b0);

        // Async reset mid-grant.
        req_a = 4'b0100;
        tick();
        chk_a("pre_rst", 4'b0100, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt_a), 32'd0);
        check("async_vld", 32'(vld_a), 32'd0);
        #1;
        rst_n = 1'b1;
        req_a = 4'b1111;
        tick();
        chk_a("post_rst", 4'b0001, 1'b0);
        req_a = 4'b0000;

        // Vector table on the unlimited-hold instance.
        for (int i = 0; i < 7; i++) begin
            req_b = tbl[i].req;
            tick();
            check($sformatf("rot%0d_gnt", i), 32'(gnt_b), 32'(tbl[i].exp_gnt));
            check($sformatf("rot%0d_vld", i), 32'(vld_b), 32'(tbl[i].exp_vld));
            check($sformatf("rot%0d_pre", i), 32'(pre_b), 32'd0);
            if (tbl[i].exp_vld)
                check($sformatf("rot%0d_id", i), 32'(id_b), 32'(tbl[i].exp_id));
        end
        req_b = '0;

`ifdef ARB_LOCK_EN
        // Lock suppresses preemption; dropping it hands off at once.
        lock_c = 1'b1;
        req_c  = 5'b00011;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lock_gnt", 32'(gnt_c), 32'b00001);
            check("lock_pre", 32'(pre_c), 32'd0);
        end
        lock_c = 1'b0;
        tick();
        check("unlock_gnt", 32'(gnt_c), 32'b00010);
        check("unlock_pre", 32'(pre_c), 32'd1);
        req_c = '0;
`endif

        // Randomised run against the reference model from a fresh reset.
        rst_n  = 1'b0;
        req_c  = '0;
        req_d  = '0;
        lock_c = 1'b0;
        mc     = '{owner: -1, ptr: 0, cnt: 0, pre: 1'b0};
        md     = '{owner: -1, ptr: 0, cnt: 0, pre: 1'b0};
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req_c = 5'($urandom);
            if ($urandom_range(0, 3) == 0) req_d = 1'($urandom);
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 5) == 0) lock_c = ~lock_c;
            lk = lock_c;
`else
            lk = 1'b0;
`endif
            mc = step(mc, 5, 4, 32'(req_c), lk);
            md = step(md, 1, 2, 32'(req_d), 1'b0);
            tick();
            cmp_model("rnd_c", mc, 32'(gnt_c), 32'(id_c), vld_c, pre_c);
            cmp_model("rnd_d", md, 32'(gnt_d), 32'(id_d), vld_d, pre_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
